jtpopeye_dwnld: RTL and testbench

- Converts the byte stream from the OSD/ARM loader (ioctl_*) into SDRAM programming writes (prog_*) and on-chip PROM writes for the Popeye core.
- Sits between the frame loader and the SDRAM programmer; the game module instantiates it inside its ROM LOAD path.
- Bytes below PROM_START go to SDRAM as 16-bit words with byte masks; bytes at or above PROM_START go to one of PROM_N colour/sprite PROMs.

---
 rtl/jtpopeye_dwnld_pkg.sv | 19 +
 rtl/jtpopeye_dwnld_skid.sv | 69 ++++++
 rtl/jtpopeye_dwnld.sv | 196 +++++++++++++++++++
 tb/tb_jtpopeye_dwnld.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/jtpopeye_dwnld_pkg.sv
// Shared types and constants for the Popeye ROM download splitter.
// region_t : where an incoming ioctl byte is routed.
// state_t  : SDRAM request FSM state.
// MASK_*   : active-low SDRAM byte-lane enables.
package jtpopeye_dwnld_pkg;

  typedef enum logic [1:0] {REG_SDRAM, REG_PROM, REG_NONE} region_t;
  typedef enum logic {IDLE, REQ} state_t;

  localparam logic [1:0] MASK_EVEN = 2'b10;
  localparam logic [1:0] MASK_ODD  = 2'b01;
  localparam logic [1:0] MASK_NONE = 2'b11;

  // Even byte addresses land on the low lane, odd ones on the high lane.
  function automatic logic [1:0] lane_mask(input logic addr_lsb);
    return addr_lsb ? MASK_ODD : MASK_EVEN;
  endfunction

endpackage

// File: rtl/jtpopeye_dwnld_skid.sv
// One-entry buffer for an SDRAM byte that arrives while a request is in flight.
// Ports:
//   clk_i, rst_i      : clock, synchronous active-high reset
//   push_i            : a byte wants to enter (addr_i/data_i)
//   ready_i           : consumer takes the held byte this cycle
//   valid_o           : a byte is held (addr_o/data_o)
//   ovf_clr_i         : clear the sticky overflow flag
//   overflow_o        : sticky, set when a push finds the buffer full
// Handshake: the held byte leaves on a cycle where valid_o && ready_i. A push
// is accepted when the buffer is empty or is being emptied on the same cycle;
// otherwise the byte is discarded and overflow_o is set.
module jtpopeye_dwnld_skid (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  logic [21:0] addr_i,
  input  logic [7:0]  data_i,
  input  logic        ready_i,
  input  logic        ovf_clr_i,
  output logic        valid_o,
  output logic [21:0] addr_o,
  output logic [7:0]  data_o,
  output logic        overflow_o
);

  logic        valid_q, valid_d;
  logic [21:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        ovf_q, ovf_d;
  logic        accept;

  assign accept = push_i && (!valid_q || ready_i);

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    if (valid_q && ready_i) valid_d = 1'b0;
    if (accept) begin
      valid_d = 1'b1;
      addr_d  = addr_i;
      data_d  = data_i;
    end
    if (ovf_clr_i) ovf_d = 1'b0;
    // A loss on the same cycle as the clear still counts.
    if (push_i && !accept) ovf_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  assign valid_o    = valid_q;
  assign addr_o     = addr_q;
  assign data_o     = data_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/jtpopeye_dwnld.sv
// Splits the loader byte stream into SDRAM programming writes and PROM writes.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   downloading                      : high during the whole ROM transfer
//   ioctl_addr/ioctl_data/ioctl_wr   : incoming bytes, ioctl_wr is a 1-cycle strobe
//   prog_rdy                         : 1-cycle SDRAM write acknowledge
//   prog_addr/prog_data/prog_mask    : SDRAM word address, byte, active-low lanes
//   prog_we                          : SDRAM request, held until prog_rdy
//   prom_addr/prom_data/prom_we      : PROM byte write, one-hot 1-cycle strobe
//   dwnld_done                       : 1-cycle pulse once the transfer has drained
//   overflow                         : sticky, an SDRAM byte was lost
//   dbg_state                        : SDRAM FSM state
// SDRAM handshake: prog_we with prog_addr/prog_data/prog_mask is held stable
// until the cycle prog_rdy is high; the request drops on the following cycle.
module jtpopeye_dwnld
  import jtpopeye_dwnld_pkg::*;
#(
  parameter logic [21:0] PROM_START = 22'h1_2000,
  parameter int          PROM_AW    = 8,
  parameter int          PROM_N     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               downloading,
  input  logic [21:0]        ioctl_addr,
  input  logic [7:0]         ioctl_data,
  input  logic               ioctl_wr,
  input  logic               prog_rdy,
  output logic [21:0]        prog_addr,
  output logic [7:0]         prog_data,
  output logic [1:0]         prog_mask,
  output logic               prog_we,
  output logic [PROM_AW-1:0] prom_addr,
  output logic [7:0]         prom_data,
  output logic [PROM_N-1:0]  prom_we,
  output logic               dwnld_done,
  output logic               overflow,
  output state_t             dbg_state
);

  localparam logic [21:0] PROM_N_W = 22'(PROM_N);

  // ---------------- region decode ----------------
  logic        byte_ok;
  logic [21:0] prom_off;
  logic [21:0] prom_idx;
  region_t     region;
  logic        sdram_in;

  assign byte_ok  = ioctl_wr && downloading;
  assign prom_off = ioctl_addr - PROM_START;
  assign prom_idx = prom_off >> PROM_AW;

  always_comb begin
    region = REG_NONE;
    if (ioctl_addr < PROM_START)  region = REG_SDRAM;
    else if (prom_idx < PROM_N_W) region = REG_PROM;
  end

  assign sdram_in = byte_ok && (region == REG_SDRAM);

  // ---------------- skid buffer ----------------
  state_t      state_q, state_d;
  logic        skid_valid, skid_take, skid_push;
  logic [21:0] skid_addr;
  logic [7:0]  skid_data;
  logic        dl_q, dl_rise, dl_fall;

  assign dl_rise = downloading && !dl_q;
  assign dl_fall = !downloading && dl_q;

  // In IDLE a held byte is issued first; a new byte arriving then takes its
  // place. In REQ every new byte must wait in the buffer, even if prog_rdy
  // arrives on the same cycle.
  assign skid_take = (state_q == IDLE) && skid_valid;
  assign skid_push = sdram_in && ((state_q == REQ) || skid_valid);

  jtpopeye_dwnld_skid u_skid (
    .clk_i      (clk),
    .rst_i      (rst),
    .push_i     (skid_push),
    .addr_i     (ioctl_addr),
    .data_i     (ioctl_data),
    .ready_i    (skid_take),
    .ovf_clr_i  (dl_rise),
    .valid_o    (skid_valid),
    .addr_o     (skid_addr),
    .data_o     (skid_data),
    .overflow_o (overflow)
  );

  // ---------------- SDRAM FSM ----------------
  logic [21:0] prog_addr_d;
  logic [7:0]  prog_data_d;
  logic [1:0]  prog_mask_d;
  logic        prog_we_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (skid_valid || sdram_in) state_d = REQ;
      REQ:     if (prog_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    prog_addr_d = prog_addr;
    prog_data_d = prog_data;
    prog_mask_d = prog_mask;
    prog_we_d   = prog_we;
    if (state_q == IDLE) begin
      if (skid_valid) begin
        prog_addr_d = {1'b0, skid_addr[21:1]};
        prog_data_d = skid_data;
        prog_mask_d = lane_mask(skid_addr[0]);
        prog_we_d   = 1'b1;
      end else if (sdram_in) begin
        prog_addr_d = {1'b0, ioctl_addr[21:1]};
        prog_data_d = ioctl_data;
        prog_mask_d = lane_mask(ioctl_addr[0]);
        prog_we_d   = 1'b1;
      end
    end else if (prog_rdy) begin
      prog_we_d   = 1'b0;
      prog_mask_d = MASK_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prog_addr <= '0;
      prog_data <= '0;
      prog_mask <= MASK_NONE;
      prog_we   <= 1'b0;
    end else begin
      prog_addr <= prog_addr_d;
      prog_data <= prog_data_d;
      prog_mask <= prog_mask_d;
      prog_we   <= prog_we_d;
    end
  end

  assign dbg_state = state_q;

  // ---------------- PROM path ----------------
  logic [PROM_N-1:0] prom_we_d;
  logic              prom_sel;

  assign prom_sel = byte_ok && (region == REG_PROM);

  always_comb begin
    prom_we_d = '0;
    for (int i = 0; i < PROM_N; i++) prom_we_d[i] = prom_sel && (prom_idx == 22'(i));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prom_addr <= '0;
      prom_data <= '0;
      prom_we   <= '0;
    end else begin
      prom_we <= prom_we_d;
      if (prom_sel) begin
        prom_addr <= prom_off[PROM_AW-1:0];
        prom_data <= ioctl_data;
      end
    end
  end

  // ---------------- end-of-transfer ----------------
  // A falling edge arms the pulse; it fires once nothing is in flight or
  // buffered. A new rising edge disarms it.
  logic pend_q, pend_now, drained;

  assign drained  = (state_q == IDLE) && !skid_valid;
  assign pend_now = pend_q || dl_fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      dl_q       <= 1'b0;
      pend_q     <= 1'b0;
      dwnld_done <= 1'b0;
    end else begin
      dl_q       <= downloading;
      pend_q     <= pend_now && !downloading && !drained;
      dwnld_done <= pend_now && !downloading && drained;
    end
  end

endmodule

// File: tb/tb_jtpopeye_dwnld.sv
module tb_jtpopeye_dwnld;
  import jtpopeye_dwnld_pkg::*;

  localparam logic [21:0] PROM_START = 22'h1_2000;

  logic        clk = 1'b0;
  logic        rst, downloading, ioctl_wr, prog_rdy;
  logic [21:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic [21:0] prog_addr;
  logic [7:0]  prog_data;
  logic [1:0]  prog_mask;
  logic        prog_we;
  logic [7:0]  prom_addr;
  logic [7:0]  prom_data;
  logic [3:0]  prom_we;
  logic        dwnld_done, overflow;
  state_t      dbg_state;

  // ---------------- clock ----------------
  always #10 clk = ~clk;

  jtpopeye_dwnld dut (
    .clk(clk), .rst(rst), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
    .prog_rdy(prog_rdy), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_mask(prog_mask), .prog_we(prog_we), .prom_addr(prom_addr),
    .prom_data(prom_data), .prom_we(prom_we), .dwnld_done(dwnld_done),
    .overflow(overflow), .dbg_state(dbg_state)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // exp_q holds accepted SDRAM bytes {addr, data} in write order; the head is
  // the one being requested when m_active. At most two bytes can be pending.
  logic [29:0] exp_q[$];
  bit          m_active, m_ovf, m_pend, m_prev_dl, m_done;
  logic [3:0]  m_prom_we;
  logic [7:0]  m_prom_addr, m_prom_data;

  task automatic model_edge();
    int  pre;
    int  off;
    bit  sd;
    pre       = exp_q.size();
    sd        = 1'b0;
    m_prom_we = '0;
    m_done    = 1'b0;
    if (rst) begin
      exp_q.delete();
      m_active  = 1'b0;
      m_ovf     = 1'b0;
      m_pend    = 1'b0;
      m_prev_dl = 1'b0;
      return;
    end
    if (downloading && !m_prev_dl) m_ovf = 1'b0;
    if (ioctl_wr && downloading) begin
      if (ioctl_addr < PROM_START) sd = 1'b1;
      else begin
        off = int'(ioctl_addr - PROM_START);
        if (off / 256 < 4) begin
          m_prom_we   = 4'(1 << (off / 256));
          m_prom_addr = 8'(off % 256);
          m_prom_data = ioctl_data;
        end
      end
    end
    if (!downloading && (m_pend || m_prev_dl)) begin
      if (pre == 0) begin m_done = 1'b1; m_pend = 1'b0; end
      else m_pend = 1'b1;
    end else m_pend = 1'b0;
    if (m_active && prog_rdy) begin
      void'(exp_q.pop_front());
      m_active = 1'b0;
    end else if (!m_active && (pre > 0 || (sd && pre < 2))) m_active = 1'b1;
    if (sd) begin
      if (pre < 2) exp_q.push_back({ioctl_addr, ioctl_data});
      else m_ovf = 1'b1;
    end
    m_prev_dl = downloading;
  endtask

  task automatic compare();
    logic [21:0] fa;
    chk("prog_we", prog_we, m_active);
    if (m_active) begin
      fa = exp_q[0][29:8];
      chk("prog_addr", prog_addr, fa >> 1);
      chk("prog_data", prog_data, exp_q[0][7:0]);
      chk("prog_mask", prog_mask, fa[0] ? 2'b01 : 2'b10);
    end else chk("prog_mask_idle", prog_mask, 2'b11);
    chk("prom_we", prom_we, m_prom_we);
    if (m_prom_we != 0) begin
      chk("prom_addr", prom_addr, m_prom_addr);
      chk("prom_data", prom_data, m_prom_data);
    end
    chk("dwnld_done", dwnld_done, m_done);
    chk("overflow", overflow, m_ovf);
  endtask

  // ---------------- driver ----------------
  task automatic cyc(input bit wr, input logic [21:0] a, input logic [7:0] d, input bit rdy);
    ioctl_wr   = wr;
    ioctl_addr = a;
    ioctl_data = d;
    prog_rdy   = rdy;
    model_edge();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, '0, '0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int acks, pulses;
    bit rdy;
    logic [21:0] a;
    rst = 1'b1; downloading = 1'b0; ioctl_wr = 1'b0; prog_rdy = 1'b0;
    ioctl_addr = '0; ioctl_data = '0;
    @(negedge clk);
    do_reset();
    chk("rst_prog_addr", prog_addr, 22'h0);
    chk("rst_prog_data", prog_data, 8'h0);
    chk("rst_prog_mask", prog_mask, 2'b11);
    chk("rst_state", dbg_state, IDLE);

    // single even byte
    downloading = 1'b1;
    idle(1);
    cyc(1'b1, 22'h00010, 8'hA5, 1'b0);
    chk("even_we", prog_we, 1'b1);
    chk("even_addr", prog_addr, 22'h00008);
    chk("even_data", prog_data, 8'hA5);
    chk("even_mask", prog_mask, 2'b10);
    idle(4);
    cyc(1'b0, '0, '0, 1'b1);
    chk("even_drop", prog_we, 1'b0);
    idle(1);

    // back-to-back odd/even
    cyc(1'b1, 22'h21, 8'h11, 1'b0);
    chk("b2b_addr0", prog_addr, 22'h10);
    chk("b2b_mask0", prog_mask, 2'b01);
    cyc(1'b1, 22'h22, 8'h22, 1'b0);
    idle(2);
    cyc(1'b0, '0, '0, 1'b1);
    chk("b2b_gap", prog_we, 1'b0);
    idle(1);
    chk("b2b_we1", prog_we, 1'b1);
    chk("b2b_addr1", prog_addr, 22'h11);
    chk("b2b_mask1", prog_mask, 2'b10);
    chk("b2b_ovf", overflow, 1'b0);
    cyc(1'b0, '0, '0, 1'b1);
    idle(2);

    // overflow on third byte, cleared by reset
    cyc(1'b1, 22'h30, 8'h01, 1'b0);
    cyc(1'b1, 22'h31, 8'h02, 1'b0);
    cyc(1'b1, 22'h32, 8'h03, 1'b0);
    chk("ovf_set", overflow, 1'b1);
    do_reset();
    chk("ovf_rst", overflow, 1'b0);
    chk("rst_we", prog_we, 1'b0);
    idle(1);

    // PROM write and out-of-range byte
    cyc(1'b1, PROM_START + 22'h105, 8'h3C, 1'b0);
    chk("prom_we1", prom_we, 4'b0010);
    chk("prom_addr1", prom_addr, 8'h05);
    chk("prom_data1", prom_data, 8'h3C);
    chk("prom_noprog", prog_we, 1'b0);
    cyc(1'b1, PROM_START + 22'd1024, 8'h77, 1'b0);
    chk("oor_prom", prom_we, 4'b0000);
    chk("oor_prog", prog_we, 1'b0);
    idle(2);

    // drain before dwnld_done
    cyc(1'b1, 22'h40, 8'h44, 1'b0);
    cyc(1'b1, 22'h41, 8'h55, 1'b0);
    downloading = 1'b0;
    acks = 0; pulses = 0;
    for (int i = 0; i < 20; i++) begin
      rdy = m_active && (i == 3 || i == 8);
      if (rdy) acks++;
      cyc(1'b0, '0, '0, rdy);
      if (dwnld_done) begin
        pulses++;
        chk("done_after_acks", acks, 2);
      end
    end
    chk("done_pulses", pulses, 1);

    // randomized traffic
    downloading = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
        continue;
      end
      if ($urandom_range(0, 99) == 0) downloading = ~downloading;
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: a = 22'($urandom_range(0, 32'h11FFF));
        6, 7, 8:          a = PROM_START + 22'($urandom_range(0, 1023));
        default:          a = PROM_START + 22'd1024 + 22'($urandom_range(0, 4095));
      endcase
      rdy = m_active ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      cyc($urandom_range(0, 2) == 0, a, 8'($urandom_range(0, 255)), rdy);
    end

    ioctl_wr = 1'b0;
    prog_rdy = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
